// File: rtl/vdf_pkg.sv
// Shared definitions for the VDF multiplier sequencers.
//   - sq_state_t : state encoding for the squaring sequencer FSM
//   - calc_*     : derivation of redundant operand geometry from the radix
//                  parameters (I_WORD, COEF_BITS, DAT_W)
//   - redun_t    : redundant operand at the default geometry, one packed
//                  coefficient per word
package vdf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sq_state_t;

    // One extra word holds the top carry of the redundant representation.
    function automatic int calc_i_word(input int num_words);
        return num_words + 1;
    endfunction

    function automatic int calc_coef_bits(input int word_bits, input int redun_word_bits);
        return word_bits + redun_word_bits;
    endfunction

    function automatic int calc_dat_w(input int word_bits, input int num_words,
                                      input int redun_word_bits);
        return calc_i_word(num_words) * calc_coef_bits(word_bits, redun_word_bits);
    endfunction

    localparam int DEF_WORD_BITS       = 8;
    localparam int DEF_NUM_WORDS       = 4;
    localparam int DEF_REDUN_WORD_BITS = 1;
    localparam int DEF_I_WORD          = calc_i_word(DEF_NUM_WORDS);
    localparam int DEF_COEF_BITS       = calc_coef_bits(DEF_WORD_BITS, DEF_REDUN_WORD_BITS);
    localparam int DEF_DAT_W           = calc_dat_w(DEF_WORD_BITS, DEF_NUM_WORDS,
                                                    DEF_REDUN_WORD_BITS);

    typedef logic [DEF_I_WORD-1:0][DEF_COEF_BITS-1:0] redun_t;

endpackage

// File: rtl/vdf_wdog_cnt.sv
// Loadable saturating up-counter with a terminal flag, used as a latency
// watchdog by the multiplier sequencers.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : load i_load_val (wins over i_inc)
//   i_inc        : count one cycle
//   o_tc         : this increment brings the count to LIMIT
module vdf_wdog_cnt #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_PRE = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Flag on the cycle whose edge reaches LIMIT, so the owner can act on
    // that same edge instead of one cycle later.
    assign o_tc = i_inc && !i_load && (cnt >= TC_PRE);

endmodule

// File: rtl/vdf_sq_sequencer.sv
// Repeated modular squaring sequencer for a pipelined multiplier.
// Loads an initial redundant value and an iteration count, issues one
// squaring at a time, feeds each result back as the next operand and
// returns the final value through a valid/ready handshake.
//   i_clk, i_rst               : clock, asynchronous active-high reset
//   i_start, i_dat, i_iter     : job request (accepted when idle)
//   i_abort                    : cancel the running job
//   o_busy                     : job in progress
//   o_mul_val, o_mul_dat_a/b   : squaring issue to the multiplier
//   i_mul_val, i_mul_dat       : multiplier result
//   o_val, i_rdy, o_dat, o_err : final result handshake, watchdog error
//   o_iter_done                : squarings completed in this/last job
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | one-cycle issue of the operand to the multiplier
// WAIT  | squaring in flight, watchdog running
// DONE  | result presented until accepted
module vdf_sq_sequencer
    import vdf_pkg::*;
#(
    parameter int WORD_BITS       = 8,
    parameter int NUM_WORDS       = 4,
    parameter int REDUN_WORD_BITS = 1,
    parameter int ITER_BITS       = 32,
    parameter int MUL_LATENCY     = 6,
    parameter int WDOG_SLACK      = 2,
    localparam int DAT_W          = calc_dat_w(WORD_BITS, NUM_WORDS, REDUN_WORD_BITS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [DAT_W-1:0]     i_dat,
    input  logic [ITER_BITS-1:0] i_iter,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_mul_val,
    output logic [DAT_W-1:0]     o_mul_dat_a,
    output logic [DAT_W-1:0]     o_mul_dat_b,
    input  logic                 i_mul_val,
    input  logic [DAT_W-1:0]     i_mul_dat,
    output logic                 o_val,
    input  logic                 i_rdy,
    output logic [DAT_W-1:0]     o_dat,
    output logic                 o_err,
    output logic [ITER_BITS-1:0] o_iter_done
);

    localparam int WDOG_LIMIT = MUL_LATENCY + WDOG_SLACK;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

    sq_state_t             state, state_nxt;
    logic [DAT_W-1:0]      op_reg;
    logic [ITER_BITS-1:0]  rem_cnt;
    logic [ITER_BITS-1:0]  iter_done;
    logic                  err_reg;
    logic                  wdog_tc;
    logic                  abort_act;

    assign abort_act = i_abort && (state != ST_IDLE);

    vdf_wdog_cnt #(
        .CNT_W (WDOG_W),
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (state == ST_ISSUE),
        .i_load_val ('0),
        .i_inc      (state == ST_WAIT),
        .o_tc       (wdog_tc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_iter == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_mul_val) begin
                    state_nxt = (rem_cnt == ITER_BITS'(1)) ? ST_DONE : ST_ISSUE;
                end else if (wdog_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_act) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        o_busy    = (state != ST_IDLE);
        o_mul_val = (state == ST_ISSUE);
        o_val     = (state == ST_DONE);
    end

    // Results are only taken in WAIT, so late or stray multiplier outputs
    // in any other state never disturb the operand.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_reg    <= '0;
            rem_cnt   <= '0;
            iter_done <= '0;
            err_reg   <= 1'b0;
        end else if (!abort_act) begin
            if (state == ST_IDLE && i_start) begin
                op_reg    <= i_dat;
                rem_cnt   <= i_iter;
                iter_done <= '0;
                err_reg   <= 1'b0;
            end else if (state == ST_WAIT) begin
                if (i_mul_val) begin
                    op_reg    <= i_mul_dat;
                    rem_cnt   <= rem_cnt - ITER_BITS'(1);
                    iter_done <= iter_done + ITER_BITS'(1);
                end else if (wdog_tc) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign o_mul_dat_a = op_reg;
    assign o_mul_dat_b = op_reg;
    assign o_dat       = op_reg;
    assign o_err       = err_reg;
    assign o_iter_done = iter_done;

endmodule
